// File: rtl/bcd_stopwatch_ctrl_if.sv
// Button pulses into, and display/status values out of, the mm:ss stopwatch controller.
interface bcd_stopwatch_ctrl_if;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [15:0] digits;
    logic        running;
    logic        lap_active;
    logic        ovf;

    modport master (
        output start_stop,
        output lap,
        output clear,
        input  digits,
        input  running,
        input  lap_active,
        input  ovf
    );

    modport slave (
        input  start_stop,
        input  lap,
        input  clear,
        output digits,
        output running,
        output lap_active,
        output ovf
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// mm:ss BCD stopwatch controller: tick prescaler, carry-chained digit counters and a
// start/pause/lap/clear state machine feeding the seven-segment scan block.
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_stopwatch_ctrl_if.slave  bus
);

    localparam int              PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PS_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PS_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [PW-1:0]   prescaler;
    logic [3:0]      d0;
    logic [3:0]      d1;
    logic [3:0]      d2;
    logic [3:0]      d3;
    logic [3:0]      d0_next;
    logic [3:0]      d1_next;
    logic [3:0]      d2_next;
    logic [3:0]      d3_next;
    logic [15:0]     lap_reg;
    logic            ovf_reg;

    logic            counting;
    logic            tick;
    logic            wrap;
    logic            do_clear;
    logic            capture_lap;

    assign counting    = (state == RUN) || (state == LAP);
    assign tick        = counting && (prescaler == PS_MAX);
    assign do_clear    = (state == PAUSE) && bus.clear;
    // The lap snapshot is only taken when lap actually wins over start_stop in RUN.
    assign capture_lap = (state == RUN) && bus.lap && !bus.start_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bus.start_stop) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bus.start_stop) begin
                    next_state = PAUSE;
                end else if (bus.lap) begin
                    next_state = LAP;
                end
            end
            LAP: begin
                if (bus.start_stop) begin
                    next_state = PAUSE;
                end else if (bus.lap) begin
                    next_state = RUN;
                end
            end
            PAUSE: begin
                if (bus.clear) begin
                    next_state = IDLE;
                end else if (bus.start_stop) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.digits     = (state == LAP) ? lap_reg : {d3, d2, d1, d0};
        bus.running    = counting;
        bus.lap_active = (state == LAP);
        bus.ovf        = ovf_reg;
    end

    // Prescaler freezes in PAUSE so a resume keeps the partial tick period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if ((state == IDLE) || do_clear) begin
            prescaler <= '0;
        end else if (counting) begin
            prescaler <= tick ? '0 : prescaler + PS_ONE;
        end
    end

    always_comb begin
        d0_next = d0;
        d1_next = d1;
        d2_next = d2;
        d3_next = d3;
        wrap    = 1'b0;
        if (tick) begin
            if (d0 == 4'd9) begin
                d0_next = 4'd0;
                if (d1 == 4'd5) begin
                    d1_next = 4'd0;
                    if (d2 == 4'd9) begin
                        d2_next = 4'd0;
                        if (d3 == 4'd5) begin
                            d3_next = 4'd0;
                            wrap    = 1'b1;
                        end else begin
                            d3_next = d3 + 4'd1;
                        end
                    end else begin
                        d2_next = d2 + 4'd1;
                    end
                end else begin
                    d1_next = d1 + 4'd1;
                end
            end else begin
                d0_next = d0 + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0 <= 4'd0;
            d1 <= 4'd0;
            d2 <= 4'd0;
            d3 <= 4'd0;
        end else if (do_clear) begin
            d0 <= 4'd0;
            d1 <= 4'd0;
            d2 <= 4'd0;
            d3 <= 4'd0;
        end else begin
            d0 <= d0_next;
            d1 <= d1_next;
            d2 <= d2_next;
            d3 <= d3_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (do_clear) begin
            ovf_reg <= 1'b0;
        end else if (wrap) begin
            ovf_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_reg <= 16'h0000;
        end else if (capture_lap) begin
            lap_reg <= {d3, d2, d1, d0};
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: a seconds-based reference model checked every cycle,
// plus directed scenarios with hand-computed display values.
module tb_bcd_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;
    localparam int M_LAP    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int assert_count = 0;
    int fail_count   = 0;

    bcd_stopwatch_ctrl_if sw_if ();

    bcd_stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw_if.slave)
    );

    always #5 clk = ~clk;

    int m_mode     = M_IDLE;
    int m_secs     = 0;
    int m_lap_secs = 0;
    int m_phase    = 0;
    bit m_ovf      = 1'b0;

    function automatic logic [15:0] to_bcd(input int secs);
        int mins;
        int s;
        mins = secs / 60;
        s    = secs % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ss, input logic lp, input logic cl);
        sw_if.start_stop = ss;
        sw_if.lap        = lp;
        sw_if.clear      = cl;
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
    endtask

    // Reference model: elapsed time as a plain seconds count, 3600 s per wrap.
    always @(posedge clk or negedge rst_n) begin
        int  old_mode;
        int  old_secs;
        bit  counting;
        bit  tick;
        if (!rst_n) begin
            m_mode     = M_IDLE;
            m_secs     = 0;
            m_lap_secs = 0;
            m_phase    = 0;
            m_ovf      = 1'b0;
        end else begin
            old_mode = m_mode;
            old_secs = m_secs;
            counting = (old_mode == M_RUN) || (old_mode == M_LAP);
            tick     = counting && (m_phase == TICK_DIV - 1);
            if (counting) m_phase = tick ? 0 : m_phase + 1;
            if (tick) begin
                if (m_secs == 3599) begin
                    m_secs = 0;
                    m_ovf  = 1'b1;
                end else begin
                    m_secs++;
                end
            end
            case (old_mode)
                M_IDLE: if (sw_if.start_stop) m_mode = M_RUN;
                M_RUN: begin
                    if (sw_if.start_stop) m_mode = M_PAUSE;
                    else if (sw_if.lap) begin
                        m_mode     = M_LAP;
                        m_lap_secs = old_secs;
                    end
                end
                M_LAP: begin
                    if (sw_if.start_stop) m_mode = M_PAUSE;
                    else if (sw_if.lap) m_mode = M_RUN;
                end
                M_PAUSE: begin
                    if (sw_if.clear) begin
                        m_mode  = M_IDLE;
                        m_secs  = 0;
                        m_phase = 0;
                        m_ovf   = 1'b0;
                    end else if (sw_if.start_stop) m_mode = M_RUN;
                end
                default: m_mode = M_IDLE;
            endcase
            if (old_mode == M_IDLE) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model_digits", sw_if.digits,
                        to_bcd((m_mode == M_LAP) ? m_lap_secs : m_secs));
            checkOutput("model_running", 16'(sw_if.running),
                        16'((m_mode == M_RUN) || (m_mode == M_LAP)));
            checkOutput("model_lap_active", 16'(sw_if.lap_active), 16'(m_mode == M_LAP));
            checkOutput("model_ovf", 16'(sw_if.ovf), 16'(m_ovf));
        end
    end

    initial begin
        sw_if.start_stop = 1'b0;
        sw_if.lap        = 1'b0;
        sw_if.clear      = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_digits", sw_if.digits, 16'h0000);
        checkOutput("reset_running", 16'(sw_if.running), 16'h0000);
        checkOutput("reset_lap_active", 16'(sw_if.lap_active), 16'h0000);
        checkOutput("reset_ovf", 16'(sw_if.ovf), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("idle_ignores_lap_clear", 16'(sw_if.running), 16'h0000);

        // Count and carry: 59 ticks of 4 cycles, then one more tick to 01:00.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (236) @(negedge clk);
        checkOutput("count_0059", sw_if.digits, 16'h0059);
        repeat (3) @(negedge clk);
        checkOutput("count_0059_hold", sw_if.digits, 16'h0059);
        @(negedge clk);
        checkOutput("count_0100", sw_if.digits, 16'h0100);
        checkOutput("count_running", 16'(sw_if.running), 16'h0001);

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clear_in_run_ignored", sw_if.digits, 16'h0100);
        checkOutput("clear_in_run_running", 16'(sw_if.running), 16'h0001);

        repeat (14155) @(negedge clk);
        checkOutput("count_5959", sw_if.digits, 16'h5959);
        checkOutput("ovf_before_wrap", 16'(sw_if.ovf), 16'h0000);
        repeat (4) @(negedge clk);
        checkOutput("wrap_digits", sw_if.digits, 16'h0000);
        checkOutput("wrap_ovf", 16'(sw_if.ovf), 16'h0001);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pause_running", 16'(sw_if.running), 16'h0000);
        checkOutput("pause_ovf_sticky", 16'(sw_if.ovf), 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clear_digits", sw_if.digits, 16'h0000);
        checkOutput("clear_ovf", 16'(sw_if.ovf), 16'h0000);
        checkOutput("clear_running", 16'(sw_if.running), 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("lap_start_0005", sw_if.digits, 16'h0005);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (11) @(negedge clk);
        checkOutput("lap_frozen_digits", sw_if.digits, 16'h0005);
        checkOutput("lap_active_high", 16'(sw_if.lap_active), 16'h0001);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("lap_release_digits", sw_if.digits, 16'h0008);
        checkOutput("lap_active_low", 16'(sw_if.lap_active), 16'h0000);

        // Pause two cycles after a tick; resume must finish the remaining two cycles.
        repeat (4) @(negedge clk);
        checkOutput("phase_tick_0009", sw_if.digits, 16'h0009);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        checkOutput("phase_paused_hold", sw_if.digits, 16'h0009);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("phase_resume_plus1", sw_if.digits, 16'h0009);
        @(negedge clk);
        checkOutput("phase_resume_plus2", sw_if.digits, 16'h0010);

        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("ss_lap_running", 16'(sw_if.running), 16'h0000);
        checkOutput("ss_lap_lap_active", 16'(sw_if.lap_active), 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("clear_ss_running", 16'(sw_if.running), 16'h0000);
        checkOutput("clear_ss_digits", sw_if.digits, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("pre_reset_lap_active", 16'(sw_if.lap_active), 16'h0001);
        checkOutput("pre_reset_digits", sw_if.digits, 16'h0001);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_digits", sw_if.digits, 16'h0000);
        checkOutput("async_reset_running", 16'(sw_if.running), 16'h0000);
        checkOutput("async_reset_lap_active", 16'(sw_if.lap_active), 16'h0000);
        checkOutput("async_reset_ovf", 16'(sw_if.ovf), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
